// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM states,
// grant owners and internal counter widths.
package mem_arbiter_pkg;

    localparam int unsigned LAT_W    = 2;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port synchronous
// memory; data has priority, bounded by a starvation limit for fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_ready,
    output logic [WORD_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_ready,
    output logic [WORD_LEN-1:0] d_rdata,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata,
    output logic                busy
);

    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic                wen_q, wen_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [WORD_LEN-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_LEN-1:0] d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wen_q, mem_wen_d;
    logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;

    logic                grant_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wen_d       = wen_q;
        lat_d       = lat_q;
        streak_d    = streak_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_wen_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = d_req && (!i_req || (streak_q < STREAK_MAX));

        case (state_q)
            ARB_IDLE: begin
                if (d_req || i_req) begin
                    state_d  = ARB_ISSUE;
                    mem_en_d = 1'b1;
                    if (grant_d) begin
                        owner_d     = OWN_D;
                        wen_d       = d_wen;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        streak_d    = i_req ? (streak_q + 4'd1) : '0;
                    end else begin
                        owner_d    = OWN_I;
                        wen_d      = 1'b0;
                        mem_addr_d = i_addr;
                        streak_d   = '0;
                    end
                    mem_wen_d = wen_d;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
                lat_d   = LAT_LAST;
            end
            ARB_WAIT: begin
                // WAIT spans MEM_LATENCY cycles so mem_rdata is sampled once
                // valid; this gives the MEM_LATENCY+2 request-to-ready latency.
                if (lat_q == '0) begin
                    state_d = ARB_DONE;
                    if (!wen_q) begin
                        if (owner_q == OWN_I) i_rdata_d = mem_rdata;
                        else                  d_rdata_d = mem_rdata;
                    end
                    i_ready_d = (owner_q == OWN_I);
                    d_ready_d = (owner_q == OWN_D);
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_I;
            wen_q       <= 1'b0;
            lat_q       <= '0;
            streak_q    <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wen_q       <= wen_d;
            lat_q       <= lat_d;
            streak_q    <= streak_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
